// File: rtl/sseg_capture_if.sv
// Multiplexed seven-segment display bus: two displays, one-cold anodes,
// active-low segments with the decimal point on bit 7.
interface sseg_capture_if;
  logic [3:0] D1_AN;
  logic [3:0] D2_AN;
  logic [7:0] D1_SEG;
  logic [7:0] D2_SEG;

  modport master (output D1_AN, D2_AN, D1_SEG, D2_SEG);
  modport slave  (input  D1_AN, D2_AN, D1_SEG, D2_SEG);
endinterface

// File: rtl/sseg_capture.sv
// Seven-segment bus capture: rebuilds HEX0..7/dpoints from the scanned display bus.
// Optional malformed-scan detection enabled by defining SSEG_CAPTURE_ERR_EN.
module sseg_capture_lane (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_i,
  input  logic       clr_i,
  input  logic [7:0] seg_i,
  output logic [6:0] hex_o,
  output logic       dp_o,
  output logic       vld_o
);
  logic [6:0] hex_q;
  logic       dp_q;
  logic       vld_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hex_q <= 7'h7F;
      dp_q  <= 1'b0;
      vld_q <= 1'b0;
    end else if (ld_i) begin
      hex_q <= seg_i[6:0];
      dp_q  <= ~seg_i[7];
      vld_q <= 1'b1;
    end else if (clr_i) begin
      vld_q <= 1'b0;
    end
  end

  assign hex_o = hex_q;
  assign dp_o  = dp_q;
  assign vld_o = vld_q;
endmodule

module sseg_capture #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
  input  logic          clk,
  input  logic          reset,
  sseg_capture_if.slave bus,
  output logic [6:0]    HEX0,
  output logic [6:0]    HEX1,
  output logic [6:0]    HEX2,
  output logic [6:0]    HEX3,
  output logic [6:0]    HEX4,
  output logic [6:0]    HEX5,
  output logic [6:0]    HEX6,
  output logic [6:0]    HEX7,
  output logic [7:0]    dpoints,
  output logic [7:0]    digit_valid,
  output logic          frame_done,
  output logic          scan_error,
  output logic          stale
);
  localparam int unsigned WD_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  SETTLE_TOP = 8'(SETTLE_CYCLES);
  localparam logic [WD_W-1:0] WD_TERM = WD_W'(TIMEOUT_CYCLES);

  logic [23:0]       bus_w, in_q;
  logic [7:0]        settle_q, settle_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [3:0]        seen_q, seen_d;
  logic              frame_q, frame_d;
  logic              stale_q, stale_d;
  logic              err_q, err_d;

  logic [3:0]        an1, an2;
  logic [1:0][7:0]   seg_sel;
  logic              chg, settle_pt, one_cold, cap, wd_hit;
  logic [1:0]        idx;
  logic [3:0]        dec;
  logic [7:0][6:0]   hex;

  assign bus_w   = {bus.D1_AN, bus.D2_AN, bus.D1_SEG, bus.D2_SEG};
  assign an1     = in_q[23:20];
  assign an2     = in_q[19:16];
  assign seg_sel = {in_q[15:8], in_q[7:0]};

  // settle point: the bus has been stable for SETTLE_CYCLES edges after in_q took it
  assign chg       = (bus_w != in_q);
  assign settle_pt = !chg && (settle_q == SETTLE_TOP - 8'd1);
  assign one_cold  = (an1 == an2) && ($countones(~an1) == 1);
  assign cap       = settle_pt && one_cold;
  assign wd_hit    = !cap && (wd_q == WD_TERM - 1'b1);

  always_comb begin
    idx = '0;
    for (int i = 0; i < 4; i++)
      if (!an2[i]) idx = 2'(i);
  end
  assign dec = 4'b0001 << idx;

  always_comb begin
    settle_d = chg ? 8'd0 : ((settle_q == SETTLE_TOP) ? settle_q : settle_q + 8'd1);
    wd_d     = wd_q;
    seen_d   = seen_q;
    frame_d  = 1'b0;
    stale_d  = stale_q;
    if (cap) begin
      wd_d    = '0;
      stale_d = 1'b0;
      if ((seen_q | dec) == 4'hF) begin
        frame_d = 1'b1;
        seen_d  = 4'h0;
      end else begin
        seen_d  = seen_q | dec;
      end
    end else if (wd_q != WD_TERM) begin
      wd_d = wd_q + 1'b1;
      if (wd_hit) begin
        stale_d = 1'b1;
        seen_d  = 4'h0;
      end
    end
  end

`ifdef SSEG_CAPTURE_ERR_EN
  logic multi0;
  assign multi0 = ($countones(~an1) > 1) || ($countones(~an2) > 1);
  always_comb err_d = err_q | (settle_pt & ((an1 != an2) | multi0));
`else
  always_comb err_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q     <= '0;
      settle_q <= '0;
      wd_q     <= '0;
      seen_q   <= '0;
      frame_q  <= 1'b0;
      stale_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      in_q     <= bus_w;
      settle_q <= settle_d;
      wd_q     <= wd_d;
      seen_q   <= seen_d;
      frame_q  <= frame_d;
      stale_q  <= stale_d;
      err_q    <= err_d;
    end
  end

  // lanes 0..3 come from display 2, lanes 4..7 from display 1
  for (genvar k = 0; k < 8; k++) begin : g_lane
    sseg_capture_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .ld_i  (cap && (idx == 2'(k % 4))),
      .clr_i (wd_hit),
      .seg_i (seg_sel[k / 4]),
      .hex_o (hex[k]),
      .dp_o  (dpoints[k]),
      .vld_o (digit_valid[k])
    );
  end

  assign HEX0 = hex[0];
  assign HEX1 = hex[1];
  assign HEX2 = hex[2];
  assign HEX3 = hex[3];
  assign HEX4 = hex[4];
  assign HEX5 = hex[5];
  assign HEX6 = hex[6];
  assign HEX7 = hex[7];

  assign frame_done = frame_q;
  assign scan_error = err_q;
  assign stale      = stale_q;
endmodule

// File: tb/tb_sseg_capture.sv
// Randomized bench for sseg_capture against a transaction-level display model.
module tb_sseg_capture;
  localparam int SETTLE = 16;
  localparam int TMO    = 2000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  sseg_capture_if bus ();
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  logic [7:0] dpoints, digit_valid;
  logic       frame_done, scan_error, stale;

  sseg_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7),
    .dpoints(dpoints), .digit_valid(digit_valid),
    .frame_done(frame_done), .scan_error(scan_error), .stale(stale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef SSEG_CAPTURE_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  int n_chk = 0;
  int n_pass = 0;

  // model of what the display should show
  logic [6:0]  m_hex [8];
  logic [7:0]  m_dp, m_vld;
  logic [3:0]  m_seen;
  logic        m_err;
  int          last_cap, frame_edge;
  logic [23:0] cur_bus;

  logic [6:0] scan_hex [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
  logic [7:0] scan_dp = 8'hA5;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  function automatic int zeros(input logic [3:0] a);
    int n = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) n++;
    return n;
  endfunction

  task automatic sync_stale(input int t);
    if (t >= last_cap + TMO) begin
      m_vld  = 8'h00;
      m_seen = 4'h0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_hex[i] = 7'h7F;
    m_dp = 8'h00; m_vld = 8'h00; m_seen = 4'h0; m_err = 1'b0;
    frame_edge = -10;
  endtask

  task automatic settle_event(input int ce);
    logic [3:0] a1, a2;
    logic [7:0] s1, s2;
    int ix;
    {a1, a2, s1, s2} = cur_bus;
    if (a1 != a2 || zeros(a1) > 1 || zeros(a2) > 1) m_err = ERR_EXP;
    if (a1 == a2 && zeros(a1) == 1) begin
      ix = 0;
      for (int i = 0; i < 4; i++) if (!a1[i]) ix = i;
      sync_stale(ce - 1);
      m_hex[ix] = s2[6:0]; m_hex[ix+4] = s1[6:0];
      m_dp[ix]  = ~s2[7];  m_dp[ix+4]  = ~s1[7];
      m_vld[ix] = 1'b1;    m_vld[ix+4] = 1'b1;
      m_seen[ix] = 1'b1;
      if (m_seen == 4'hF) begin
        frame_edge = ce;
        m_seen = 4'h0;
      end
      last_cap = ce;
    end
  endtask

  task automatic check_all();
    sync_stale(cyc);
    chk("hex", {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0},
        {m_hex[7], m_hex[6], m_hex[5], m_hex[4], m_hex[3], m_hex[2], m_hex[1], m_hex[0]});
    chk("dpoints", dpoints, m_dp);
    chk("digit_valid", digit_valid, m_vld);
    chk("frame_done", frame_done, cyc == frame_edge);
    chk("scan_error", scan_error, m_err);
    chk("stale", stale, cyc >= last_cap + TMO);
  endtask

  // drive a new bus value at a negedge and hold it for n edges, checking each cycle
  task automatic hold(input logic [3:0] a1, input logic [3:0] a2,
                      input logic [7:0] s1, input logic [7:0] s2, input int n);
    logic [23:0] nb;
    int ce;
    nb = {a1, a2, s1, s2};
    if (nb == cur_bus || nb == 24'h0) nb[0] = ~nb[0];
    cur_bus = nb;
    bus.D1_AN = nb[23:20]; bus.D2_AN = nb[19:16];
    bus.D1_SEG = nb[15:8]; bus.D2_SEG = nb[7:0];
    ce = cyc + 1 + SETTLE;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (cyc == ce) settle_event(ce);
      check_all();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    last_cap = cyc;
    check_all();
  endtask

  task automatic scan_frames(input int frames);
    logic [3:0] a;
    for (int f = 0; f < frames; f++)
      for (int i = 0; i < 4; i++) begin
        a = ~(4'b0001 << i);
        hold(a, a, {~scan_dp[i+4], scan_hex[i+4]}, {~scan_dp[i], scan_hex[i]}, 100);
      end
  endtask

  initial begin
    logic [7:0] v;
    logic [3:0] a1, a2;
    int r;
    cur_bus = 24'hFFFFFF;
    bus.D1_AN = 4'hF; bus.D2_AN = 4'hF; bus.D1_SEG = 8'hFF; bus.D2_SEG = 8'hFF;
    model_reset();
    last_cap = 0;
    @(negedge clk);
    do_reset();
    chk("rst_hex0", HEX0, 7'h7F);

    // normal scan
    scan_frames(3);
    chk("scan_vld", digit_valid, 8'hFF);
    chk("scan_hex0", HEX0, 7'h40);
    chk("scan_hex7", HEX7, 7'h78);
    chk("scan_dp", dpoints, 8'hA5);

    // glitch on D2_SEG[0] ten cycles into a dwell
    v = 8'h92;
    hold(4'b1110, 4'b1110, 8'hC0, v, 10);
    for (int g = 0; g < 5; g++)
      hold(4'b1110, 4'b1110, 8'hC0, (g % 2 == 0) ? (v ^ 8'h01) : v, 1);
    hold(4'b1110, 4'b1110, 8'hC0, v, 40);
    chk("glitch_hex0", HEX0, 7'h12);

    // malformed scan: anodes disagree
    hold(4'b1110, 4'b1101, 8'h00, 8'h00, 20);
    chk("mal_err", scan_error, ERR_EXP);
    chk("mal_hex0", HEX0, 7'h12);
    hold(4'b1011, 4'b1011, 8'h3C, 8'h5A, 30);

    // random bus traffic
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        a1 = ~(4'b0001 << $urandom_range(0, 3)); a2 = a1;
      end else if (r < 7) begin
        a1 = 4'hF; a2 = 4'hF;
      end else if (r < 8) begin
        a1 = 4'($urandom); a2 = 4'($urandom);
      end else begin
        a1 = 4'($urandom) & 4'b1100 | 4'b0010; a2 = a1;
      end
      hold(a1, a2, 8'($urandom), 8'($urandom), $urandom_range(1, 40));
    end

    // stall with blank anodes, then recovery
    scan_frames(1);
    hold(4'hF, 4'hF, 8'hFF, 8'hFF, TMO + 100);
    chk("stall_stale", stale, 1'b1);
    chk("stall_vld", digit_valid, 8'h00);
    hold(4'b0111, 4'b0111, 8'h81, 8'h7E, 30);
    chk("recover_stale", stale, 1'b0);
    chk("recover_vld", digit_valid, 8'h88);

    // reset mid-settle, then a fresh capture
    hold(4'b1110, 4'b1110, 8'h11, 8'h22, 10);
    do_reset();
    chk("mid_rst_hex0", HEX0, 7'h7F);
    chk("mid_rst_vld", digit_valid, 8'h00);
    hold(4'b1110, 4'b1110, 8'h33, 8'h44, 30);
    chk("post_rst_hex0", HEX0, 7'h44);
    scan_frames(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sseg_capture.md
# sseg_capture

Receive-side counterpart of the Boolean-board seven-segment display driver: observes the multiplexed anode/segment bus (D1_AN, D2_AN, D1_SEG, D2_SEG) and reconstructs the eight 7-bit digit patterns and eight decimal-point bits that produced it. It serves as a loopback checker and scoreboard front-end in the board-level test harness, and as a capture block for the display bus of an external board. It also tracks per-digit validity, signals complete scan frames, and flags stalled or malformed scanning.

## Interface
- SETTLE_CYCLES, 16: consecutive cycles all bus inputs must stay unchanged before a capture; range 1..255.
- TIMEOUT_CYCLES, 200_000: cycles without a capture before stale asserts; must exceed 2x the driver dwell (100_000).
- clk  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- D1_AN, D2_AN  input  4 each  one-cold anode selects, display 1 / display 2.
- D1_SEG, D2_SEG  input  8 each  active-low segments; bit 7 is the DP, bits 6:0 are the segment pattern.
- HEX0..HEX7  output  7 each  captured active-low patterns. D2 carries HEX0..HEX3; D1 carries HEX4..HEX7.
- dpoints  output  8  captured decimal points, active-high (inverted bus bit 7).
- digit_valid  output  8  bit i is set once HEXi has been captured since reset or since the last stale event.
- frame_done  output  1  one-cycle pulse when all four anode indices have been captured since the previous pulse.
- scan_error  output  1  sticky malformed-scan flag.
- stale  output  1  no capture within TIMEOUT_CYCLES.

## Operation
- Input stage: all 24 bus bits are registered once (in_q).
  - Any difference between in_q and its previous value clears settle_cnt and re-arms capture.
- Settle counter: settle_cnt increments while in_q is unchanged and saturates at SETTLE_CYCLES.
- Capture fires once per stable period, when settle_cnt reaches SETTLE_CYCLES. Capture is valid only when:
  - D1_AN == D2_AN, and
  - exactly one anode bit is 0, at index i.
- On a valid capture:
  - HEX[i] <= D2_SEG[6:0]; HEX[i+4] <= D1_SEG[6:0].
  - dpoints[i] <= ~D2_SEG[7]; dpoints[i+4] <= ~D1_SEG[7].
  - digit_valid[i] and digit_valid[i+4] are set.
  - seen[i] is set.
  - The watchdog is cleared and stale is cleared.
- Anodes all 1 (blank): no capture, no error.
- Frame tracking:
  - When seen becomes 4'b1111, frame_done pulses on the same edge as the completing capture, and seen clears on that edge.
  - A repeated index before completion does not pulse frame_done.
- Watchdog:
  - Counts every cycle and clears on each valid capture.
  - On reaching TIMEOUT_CYCLES: stale <= 1, digit_valid <= 0, seen <= 0. The count holds at the terminal value.
- Reset: HEX0..HEX7 = 7'h7F; dpoints, digit_valid, seen = 0; frame_done, scan_error, stale = 0; all counters = 0.
  - Reset mid-settle discards the pending capture.

## Timing
- Let E0 be the first clk edge that samples a new bus value into in_q. If the bus then stays constant:
  - capture outputs update at edge E0 + SETTLE_CYCLES;
  - frame_done is high in the cycle following that edge.
- A bus change at any edge before E0 + SETTLE_CYCLES restarts the count from the new E0. Only the final stable value is captured.
- A reset on the same edge as a capture wins; outputs take their reset values.
- Capture and timeout on the same edge: capture wins; stale stays 0 and the watchdog restarts.
- Watchdog width is $clog2(TIMEOUT_CYCLES+1). settle_cnt width is 8.

## Configuration
- SSEG_CAPTURE_ERR_EN defined: scan_error sets at the settle point on either condition below, and stays set until reset:
  - D1_AN != D2_AN, or
  - more than one anode bit is 0.
- SSEG_CAPTURE_ERR_EN undefined: scan_error is tied to 0. Malformed patterns are silently skipped (no capture).

## Test plan
- Normal scan, SETTLE_CYCLES=16, TIMEOUT_CYCLES=2000, dwell 100 cycles.
  - Stimulus: drive a driver model with HEX0..7 = 7'h40,7'h79,7'h24,7'h30,7'h19,7'h12,7'h02,7'h78 and dpoints = 8'hA5.
  - Response: outputs match exactly after the first frame. digit_valid = 8'hFF. frame_done pulses every 400 cycles.
- Glitch rejection.
  - Stimulus: toggle D2_SEG[0] for 5 cycles, 10 cycles into a dwell.
  - Response: HEX0 equals the post-glitch value, updated exactly 16 edges after the last change.
- Stall.
  - Stimulus: freeze the anodes at 4'b1111 for 2000 cycles.
  - Response: stale = 1 and digit_valid = 0. On the next valid capture, stale returns to 0.
- Malformed scan (macro defined).
  - Stimulus: D1_AN = 4'b1110, D2_AN = 4'b1101, held for 20 cycles.
  - Response: scan_error = 1 and sticky. HEX unchanged. With the macro undefined, scan_error = 0.
- Mid-dwell reset.
  - Stimulus: assert reset for 1 cycle at settle count 10.
  - Response: HEX0 = 7'h7F and digit_valid = 0. The next capture occurs 16 edges after the next bus change.
